hazard_scoreboard: RTL

//  Decode-side hazard detector; the producer of the stall decisions that operand forwarding relaxes.

---
 rtl/hazard_scoreboard_pkg.sv | 16 +
 rtl/hazard_scoreboard_reg_pending_table.sv | 62 ++++++
 rtl/hazard_scoreboard.sv | 78 +++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared sizing for the hazard scoreboard, forwarding unit and register file.
// Register address width is derived from the register count.
package hazard_scoreboard_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int CNT_W    = 2;
  localparam int PERF_W   = 16;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  pend_cnt_t;

endpackage

// File: rtl/hazard_scoreboard_reg_pending_table.sv
// Per-register count of in-flight writes (EX/MEM/WB), with one increment port,
// one decrement port and two read ports that see a same-cycle decrement.
module reg_pending_table
  import hazard_scoreboard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      inc_en,
  input  reg_addr_t inc_addr,
  input  logic      dec_en,
  input  reg_addr_t dec_addr,
  input  reg_addr_t rd_addr1,
  input  reg_addr_t rd_addr2,
  output pend_cnt_t rd_eff1,
  output pend_cnt_t rd_eff2,
  output logic      overflow,
  output logic      underflow
);

  logic [NUM_REGS-1:0][CNT_W-1:0] pend_vec;
  logic [NUM_REGS-1:0]            ovf_vec;
  logic [NUM_REGS-1:0]            unf_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
      pend_cnt_t cnt_reg;
      logic      inc_hit;
      logic      dec_hit;

      assign inc_hit = inc_en && (inc_addr == reg_addr_t'(gi));
      assign dec_hit = dec_en && (dec_addr == reg_addr_t'(gi));
      // A simultaneous issue and retire on one register cancel out.
      assign ovf_vec[gi]  = inc_hit && !dec_hit && (cnt_reg == CNT_MAX);
      assign unf_vec[gi]  = dec_hit && !inc_hit && (cnt_reg == '0);
      assign pend_vec[gi] = cnt_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg <= '0;
        end else if (inc_hit && !dec_hit && !ovf_vec[gi]) begin
          cnt_reg <= cnt_reg + 1'b1;
        end else if (dec_hit && !inc_hit && !unf_vec[gi]) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
    end
  endgenerate

  logic byp1;
  logic byp2;

  // The retiring write is visible to ID in the same cycle (register file write-through).
  assign byp1 = dec_en && (dec_addr == rd_addr1);
  assign byp2 = dec_en && (dec_addr == rd_addr2);

  assign rd_eff1   = pend_vec[rd_addr1] - pend_cnt_t'(byp1);
  assign rd_eff2   = pend_vec[rd_addr2] - pend_cnt_t'(byp2);
  assign overflow  = |ovf_vec;
  assign underflow = |unf_vec;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard detector: RAW stalls from the pending-write table, or only
// load-use stalls when forwarding is on; also counts stalled cycles.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en_forwarding,
  input  logic              freeze,
  input  logic              flush,
  input  logic              ID_valid,
  input  logic [ADDR_W-1:0] ID_src1,
  input  logic [ADDR_W-1:0] ID_src2,
  input  logic              ID_two_src,
  input  logic              ID_wb_en,
  input  logic [ADDR_W-1:0] ID_dst,
  input  logic              EX_wb_en,
  input  logic              EX_mem_read,
  input  logic [ADDR_W-1:0] EX_dst,
  input  logic              WB_wb_en,
  input  logic [ADDR_W-1:0] WB_dst,
  output logic              hazard,
  output logic              sb_error,
  output logic [PERF_W-1:0] stall_cycles
);

  pend_cnt_t eff1;
  pend_cnt_t eff2;
  logic      overflow;
  logic      underflow;
  logic      raw;
  logic      load_use;
  logic      issue;
  logic      retire;
  logic      sb_error_reg;
  logic [PERF_W-1:0] stall_cycles_reg;

  reg_pending_table u_table (
    .clk       (clk),
    .rst       (rst),
    .inc_en    (issue),
    .inc_addr  (ID_dst),
    .dec_en    (retire),
    .dec_addr  (WB_dst),
    .rd_addr1  (ID_src1),
    .rd_addr2  (ID_src2),
    .rd_eff1   (eff1),
    .rd_eff2   (eff2),
    .overflow  (overflow),
    .underflow (underflow)
  );

  assign raw      = ID_valid && ((eff1 != '0) || (ID_two_src && (eff2 != '0)));
  assign load_use = ID_valid && EX_wb_en && EX_mem_read &&
                    ((EX_dst == ID_src1) || (ID_two_src && (EX_dst == ID_src2)));
  assign hazard   = en_forwarding ? load_use : raw;

  assign issue  = ID_valid && ID_wb_en && !hazard && !freeze && !flush;
  assign retire = WB_wb_en && !freeze;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_error_reg     <= 1'b0;
      stall_cycles_reg <= '0;
    end else begin
      if (overflow || underflow) begin
        sb_error_reg <= 1'b1;
      end
      if (hazard && !freeze && (stall_cycles_reg != PERF_MAX)) begin
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
      end
    end
  end

  assign sb_error     = sb_error_reg;
  assign stall_cycles = stall_cycles_reg;

endmodule
